// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier controller:
// chunk width and FSM state encoding.
package vedic_pkg;
   localparam int CHUNK_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ABS,
      MUL,
      SIGN,
      DONE
   } state_e;
endpackage

// File: rtl/vedic_mult_8bit.sv
// Unsigned 8x8 -> 16 multiplier built Urdhva-style from four 4x4 nibble
// products combined crosswise.
module vedic_mult_8bit (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] p_o
);
   logic [7:0] ll, lh, hl, hh;

   assign ll = {4'b0, a_i[3:0]} * {4'b0, b_i[3:0]};
   assign lh = {4'b0, a_i[3:0]} * {4'b0, b_i[7:4]};
   assign hl = {4'b0, a_i[7:4]} * {4'b0, b_i[3:0]};
   assign hh = {4'b0, a_i[7:4]} * {4'b0, b_i[7:4]};

   // Vertical terms concatenate; the two crosswise terms land one nibble up.
   assign p_o = {hh, ll} + ({8'b0, lh} << 4) + ({8'b0, hl} << 4);
endmodule

// File: rtl/vedic_seq_mult_ctrl.sv
// WxW signed multiplier that time-multiplexes one 8x8 Vedic core over operand
// chunks. Define VEDIC_SEQ_ZSKIP_EN to retire all-zero multiplicand rows in one cycle.
module vedic_seq_mult_ctrl
   import vedic_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out
);
   localparam int N  = W / CHUNK_W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic             neg_q, neg_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [CW-1:0]    i_q, i_d, j_q, j_d;
   logic [2*W-1:0]   out_q, out_d;
   logic             out_valid_q, in_ready_q;

   logic [CHUNK_W-1:0]   chunk_a, chunk_b;
   logic [2*CHUNK_W-1:0] pp;
   logic [2*W-1:0]       pp_ext;
   logic                 skip_row;
   int                   shamt;

   // After ABS, a_q/b_q hold magnitudes; chunk i of |a|, chunk j of |b|.
   assign chunk_a = a_q[i_q*CHUNK_W +: CHUNK_W];
   assign chunk_b = b_q[j_q*CHUNK_W +: CHUNK_W];

   vedic_mult_8bit u_mult (
      .a_i (chunk_a),
      .b_i (chunk_b),
      .p_o (pp)
   );

   assign pp_ext = {{(2*W-2*CHUNK_W){1'b0}}, pp};
   assign shamt  = (int'(i_q) + int'(j_q)) * CHUNK_W;

`ifdef VEDIC_SEQ_ZSKIP_EN
   assign skip_row = (chunk_a == '0);
`else
   assign skip_row = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
      out_d   = out_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               neg_d   = a[W-1] ^ b[W-1];
               state_d = ABS;
            end
         end
         ABS: begin
            // -2^(W-1) negates to itself, which read unsigned is the right magnitude.
            a_d     = a_q[W-1] ? -a_q : a_q;
            b_d     = b_q[W-1] ? -b_q : b_q;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
            state_d = MUL;
         end
         MUL: begin
            if (skip_row || j_q == LAST) begin
               j_d = '0;
               if (i_q == LAST) state_d = SIGN;
               else             i_d     = i_q + 1'b1;
            end else begin
               j_d = j_q + 1'b1;
            end
            if (!skip_row) acc_d = acc_q + (pp_ext << shamt);
         end
         SIGN: begin
            out_d   = neg_q ? -acc_q : acc_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
         i_q         <= i_d;
         j_q         <= j_d;
         out_q       <= out_d;
         out_valid_q <= (state_d == DONE);
         in_ready_q  <= (state_d == IDLE);
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
endmodule
